// File: rtl/mem_read_checker.sv
// mem_read_checker
// Consumer end of the memctrl address-stepping interface. Rebuilds the address
// counter's step cadence from the shared enable, compares read data against the
// expected pattern on every step edge, and logs each failing address once into
// a small fault register file that the BISR repair logic reads back by index.
//
// Optional feature: define CHECKER_MASK_EN to add a MASK input; only bits set
// in MASK take part in the data comparison.
module mem_read_checker #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int LEAD        = 5,
    parameter int PERIOD      = 4,
    parameter int FAULT_DEPTH = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           EN,
    input  logic [ADDR_W-1:0]              ADDR,
    input  logic [DATA_W-1:0]              RDATA,
    input  logic [DATA_W-1:0]              EXP_DATA,
`ifdef CHECKER_MASK_EN
    input  logic [DATA_W-1:0]              MASK,
`endif
    input  logic                           CLR,
    input  logic [$clog2(FAULT_DEPTH)-1:0] RD_IDX,
    output logic [ADDR_W-1:0]              RD_ADDR,
    output logic                           RD_VALID,
    output logic                           SAMPLE,
    output logic [$clog2(FAULT_DEPTH):0]   FAULT_CNT,
    output logic                           FAULT_FULL,
    output logic                           OVERFLOW
);

    localparam int IDX_W = $clog2(FAULT_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Phase values at which the current lead-in / period completes.
    localparam logic [2:0] LEAD_LAST   = 3'(LEAD - 1);
    localparam logic [2:0] PERIOD_LAST = 3'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FAULT_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] phase_reg, phase_next;
    logic       sample_edge;
    logic       sample_reg;

    logic [ADDR_W-1:0] addr_reg [FAULT_DEPTH];
    logic [FAULT_DEPTH-1:0] valid_reg;
    logic [FAULT_DEPTH-1:0] hit;
    logic [CNT_W-1:0]  cnt_reg;
    logic              overflow_reg;

    logic [DATA_W-1:0] diff;
    logic              mismatch;
    logic              dup;
    logic              full;
    logic              push;
    logic [IDX_W-1:0]  wr_idx;

    // ------------------------------------------------------------------
    // Cadence FSM
    // ------------------------------------------------------------------

    // State and phase register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            phase_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    // Next state: dropping EN always aborts back to IDLE so a restart repeats the lead-in.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        if (!EN) begin
            state_next = ST_IDLE;
            phase_next = 3'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // The first EN-high cycle is lead cycle 0; with LEAD==1 it is already the sample.
                    if (sample_edge) begin
                        state_next = ST_RUN;
                        phase_next = 3'd0;
                    end else begin
                        state_next = ST_LEAD;
                        phase_next = 3'd1;
                    end
                end
                ST_LEAD: begin
                    if (sample_edge) begin
                        state_next = ST_RUN;
                        phase_next = 3'd0;
                    end else begin
                        phase_next = phase_reg + 3'd1;
                    end
                end
                ST_RUN: begin
                    if (sample_edge) begin
                        phase_next = 3'd0;
                    end else begin
                        phase_next = phase_reg + 3'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    phase_next = 3'd0;
                end
            endcase
        end
    end

    // Output decode: this edge is a step edge of the address counter.
    always_comb begin
        sample_edge = 1'b0;
        if (EN) begin
            case (state_reg)
                ST_IDLE: sample_edge = (LEAD == 1);
                ST_LEAD: sample_edge = (phase_reg == LEAD_LAST);
                ST_RUN:  sample_edge = (phase_reg == PERIOD_LAST);
                default: sample_edge = 1'b0;
            endcase
        end
    end

    // One-cycle SAMPLE pulse following every step edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sample_reg <= 1'b0;
        end else begin
            sample_reg <= sample_edge;
        end
    end

    // ------------------------------------------------------------------
    // Compare and fault logging
    // ------------------------------------------------------------------

`ifdef CHECKER_MASK_EN
    assign diff = (RDATA ^ EXP_DATA) & MASK;
`else
    assign diff = RDATA ^ EXP_DATA;
`endif
    assign mismatch = |diff;

    // Parallel duplicate search across every occupied entry.
    generate
        for (genvar gi = 0; gi < FAULT_DEPTH; gi++) begin : g_hit
            assign hit[gi] = valid_reg[gi] && (addr_reg[gi] == ADDR);
        end
    endgenerate

    assign dup    = |hit;
    assign full   = (cnt_reg == CNT_FULL);
    assign wr_idx = cnt_reg[IDX_W-1:0];
    assign push   = sample_edge && mismatch && !CLR && !dup && !full;

    // Fault entries: filled in order at the current count, cleared as a whole.
    generate
        for (genvar gi = 0; gi < FAULT_DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (RST) begin
                    valid_reg[gi] <= 1'b0;
                    addr_reg[gi]  <= '0;
                end else if (CLR) begin
                    valid_reg[gi] <= 1'b0;
                end else if (push && (wr_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                    addr_reg[gi]  <= ADDR;
                end
            end
        end
    endgenerate

    // Fault count and sticky overflow when a new fault finds the list full.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else if (sample_edge && mismatch && !dup) begin
            if (full) begin
                overflow_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Read-back port; unoccupied entries read as zero.
    assign RD_VALID   = valid_reg[RD_IDX];
    assign RD_ADDR    = valid_reg[RD_IDX] ? addr_reg[RD_IDX] : '0;
    assign SAMPLE     = sample_reg;
    assign FAULT_CNT  = cnt_reg;
    assign FAULT_FULL = full;
    assign OVERFLOW   = overflow_reg;

endmodule

// File: tb/tb_mem_read_checker.sv
// tb_mem_read_checker
// Directed bench for mem_read_checker with default parameters.
module tb_mem_read_checker;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [15:0] ADDR;
    logic [31:0] RDATA;
    logic [31:0] EXP_DATA;
    logic        CLR;
    logic [2:0]  RD_IDX;
    logic [15:0] RD_ADDR;
    logic        RD_VALID;
    logic        SAMPLE;
    logic [3:0]  FAULT_CNT;
    logic        FAULT_FULL;
    logic        OVERFLOW;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    mem_read_checker dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .ADDR       (ADDR),
        .RDATA      (RDATA),
        .EXP_DATA   (EXP_DATA),
`ifdef CHECKER_MASK_EN
        .MASK       (32'hFFFF_FFFF),
`endif
        .CLR        (CLR),
        .RD_IDX     (RD_IDX),
        .RD_ADDR    (RD_ADDR),
        .RD_VALID   (RD_VALID),
        .SAMPLE     (SAMPLE),
        .FAULT_CNT  (FAULT_CNT),
        .FAULT_FULL (FAULT_FULL),
        .OVERFLOW   (OVERFLOW)
    );

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-16s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-16s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs set after this apply to the next edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Address the counter presents before EN-high edge k (k starts at 1).
    function automatic logic [15:0] addr_at(input int k);
        if (k <= 5) return 16'd0;
        return 16'((k - 6) / 4 + 1);
    endfunction

    initial begin
        RST = 1'b1; EN = 1'b0; CLR = 1'b0; ADDR = '0;
        RDATA = '0; EXP_DATA = '0; RD_IDX = '0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("rst_sample",   32'(SAMPLE),     32'd0);
        check("rst_cnt",      32'(FAULT_CNT),  32'd0);
        check("rst_ovf",      32'(OVERFLOW),   32'd0);
        check("rst_full",     32'(FAULT_FULL), 32'd0);
        check("rst_valid",    32'(RD_VALID),   32'd0);
        check("rst_rdaddr",   32'(RD_ADDR),    32'd0);

        // Clean run: samples follow EN-high edges 5, 9, 13, 17.
        for (int k = 1; k <= 20; k++) begin
            EN = 1'b1; ADDR = addr_at(k);
            EXP_DATA = 32'hA5A5_0000 | 32'(k); RDATA = EXP_DATA;
            tick();
            check("t1_sample", 32'(SAMPLE), 32'(k == 5 || k == 9 || k == 13 || k == 17));
        end
        check("t1_cnt", 32'(FAULT_CNT), 32'd0);
        EN = 1'b0;
        tick();

        // Mismatch only at address 3 (sampled at edge 17).
        for (int k = 1; k <= 20; k++) begin
            EN = 1'b1; ADDR = addr_at(k);
            EXP_DATA = 32'h1234_0000 | 32'(k);
            RDATA = (ADDR == 16'd3) ? ~EXP_DATA : EXP_DATA;
            tick();
        end
        EN = 1'b0;
        tick();
        check("t2_cnt", 32'(FAULT_CNT), 32'd1);
        check("t2_ovf", 32'(OVERFLOW),  32'd0);
        RD_IDX = 3'd0; #1;
        check("t2_addr0",  32'(RD_ADDR),  32'd3);
        check("t2_valid0", 32'(RD_VALID), 32'd1);
        RD_IDX = 3'd1; #1;
        check("t2_valid1", 32'(RD_VALID), 32'd0);
        check("t2_addr1",  32'(RD_ADDR),  32'd0);

        // EN glitch after 3 high cycles restarts the lead-in.
        RDATA = 32'h0; EXP_DATA = 32'h0; ADDR = 16'd0;
        for (int k = 1; k <= 3; k++) begin
            EN = 1'b1;
            tick();
            check("t3_pre", 32'(SAMPLE), 32'd0);
        end
        EN = 1'b0;
        tick();
        check("t3_low", 32'(SAMPLE), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            EN = 1'b1;
            tick();
            check("t3_run", 32'(SAMPLE), 32'(k == 5));
        end
        EN = 1'b0;
        tick();

        // Ten distinct failing addresses overflow an 8-entry list.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("t4_clr_cnt", 32'(FAULT_CNT), 32'd0);
        for (int k = 1; k <= 41; k++) begin
            EN = 1'b1; ADDR = 16'h100 + 16'd3 * addr_at(k);
            EXP_DATA = 32'hC0DE_0000 | 32'(k); RDATA = ~EXP_DATA;
            tick();
            if (k == 33) begin
                check("t4_full8",  32'(FAULT_FULL), 32'd1);
                check("t4_ovf8",   32'(OVERFLOW),   32'd0);
            end
            if (k == 37) check("t4_ovf9", 32'(OVERFLOW), 32'd1);
        end
        EN = 1'b0;
        tick();
        check("t4_cnt",  32'(FAULT_CNT),  32'd8);
        check("t4_full", 32'(FAULT_FULL), 32'd1);
        check("t4_ovf",  32'(OVERFLOW),   32'd1);
        for (int i = 0; i < 8; i++) begin
            RD_IDX = 3'(i); #1;
            check("t4_entry", 32'(RD_ADDR),  32'h100 + 32'(3 * i));
            check("t4_valid", 32'(RD_VALID), 32'd1);
        end

        // Address 7 fails at two samples; a later CLR edge wins over a push.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            EN = 1'b1; ADDR = 16'd7;
            EXP_DATA = 32'h7777_0000 | 32'(k); RDATA = ~EXP_DATA;
            tick();
            if (k == 5) check("t5_first", 32'(FAULT_CNT), 32'd1);
        end
        check("t5_nodup", 32'(FAULT_CNT), 32'd1);
        RD_IDX = 3'd0; #1;
        check("t5_addr0", 32'(RD_ADDR), 32'd7);
        RD_IDX = 3'd1; #1;
        check("t5_valid1", 32'(RD_VALID), 32'd0);
        for (int k = 10; k <= 13; k++) begin
            ADDR = 16'd8; CLR = (k == 13);
            tick();
        end
        CLR = 1'b0;
        check("t5_clr_cnt",  32'(FAULT_CNT), 32'd0);
        check("t5_clr_smp",  32'(SAMPLE),    32'd1);
        RD_IDX = 3'd0; #1;
        check("t5_clr_val",  32'(RD_VALID),  32'd0);
        for (int k = 14; k <= 17; k++) begin
            ADDR = 16'd9;
            tick();
        end
        check("t5_after_cnt", 32'(FAULT_CNT), 32'd1);
        check("t5_after_adr", 32'(RD_ADDR),   32'd9);
        EN = 1'b0;
        tick();

        // Reset on a sample edge with a pending mismatch.
        for (int k = 1; k <= 5; k++) begin
            EN = 1'b1; ADDR = 16'd20; RST = (k == 5);
            EXP_DATA = 32'h2020_0000; RDATA = 32'h2020_0001;
            tick();
        end
        RST = 1'b0;
        RD_IDX = 3'd0; #1;
        check("t6_sample", 32'(SAMPLE),     32'd0);
        check("t6_cnt",    32'(FAULT_CNT),  32'd0);
        check("t6_ovf",    32'(OVERFLOW),   32'd0);
        check("t6_full",   32'(FAULT_FULL), 32'd0);
        check("t6_valid",  32'(RD_VALID),   32'd0);
        check("t6_rdaddr", 32'(RD_ADDR),    32'd0);
        for (int k = 1; k <= 5; k++) begin
            EN = 1'b1;
            tick();
            check("t6_relead", 32'(SAMPLE), 32'(k == 5));
        end
        check("t6_push", 32'(FAULT_CNT), 32'd1);
        EN = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
